// File: rtl/addsub_sequencer_if.sv
// Operand/opcode request stream and result/flag response stream of the add/sub sequencer.
// The master drives requests and accepts results; the sequencer is the slave.
interface addsub_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_c;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_q, out_c, out_z, out_n, out_v
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_q, out_c, out_z, out_n, out_v
  );
endinterface

// File: rtl/addsub_sequencer.sv
// Control stage for an external ripple-carry adder: ADD in one adder pass, SUB as a + ~b then +1.
// Results are registered one cycle after reaching DONE and held until the consumer accepts them.
module addsub_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_sequencer_if.slave bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_q,
  input  logic             add_cout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS1 = 2'd1;
  localparam logic [1:0] PASS2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             op_r;
  logic [WIDTH-1:0] s1;
  logic             c1;
  logic [WIDTH-1:0] s2;
  logic             c2;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_q_r;
  logic             out_c_r;
  logic             out_z_r;
  logic             out_n_r;
  logic             out_v_r;

  logic [WIDTH-1:0] res_q;
  logic             res_c;
  logic             res_v;

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_c     = out_c_r;
  assign bus.out_z     = out_z_r;
  assign bus.out_n     = out_n_r;
  assign bus.out_v     = out_v_r;

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      PASS1: begin
        add_a = a_r;
        add_b = op_r ? ~b_r : b_r;
      end
      PASS2: begin
        add_a = s1;
        add_b = ONE;
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  // For SUB, carry out of either pass means no borrow; overflow compares operand signs
  always_comb begin
    res_q = op_r ? s2 : s1;
    res_c = op_r ? (c1 | c2) : c1;
    if (op_r)
      res_v = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_q[WIDTH-1] != a_r[WIDTH-1]);
    else
      res_v = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_q[WIDTH-1] != a_r[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 1'b0;
      s1          <= '0;
      c1          <= 1'b0;
      s2          <= '0;
      c2          <= 1'b0;
      out_valid_r <= 1'b0;
      out_q_r     <= '0;
      out_c_r     <= 1'b0;
      out_z_r     <= 1'b0;
      out_n_r     <= 1'b0;
      out_v_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.in_a;
            b_r   <= bus.in_b;
            op_r  <= bus.in_op;
            state <= PASS1;
          end
        end
        PASS1: begin
          s1    <= add_q;
          c1    <= add_cout;
          state <= op_r ? PASS2 : DONE;
        end
        PASS2: begin
          s2    <= add_q;
          c2    <= add_cout;
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle captures the result; afterwards wait for the consumer
          if (!out_valid_r) begin
            out_q_r     <= res_q;
            out_c_r     <= res_c;
            out_z_r     <= (res_q == '0);
            out_n_r     <= res_q[WIDTH-1];
            out_v_r     <= res_v;
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer: directed vector table, random operations against
// an arithmetic reference model, plus backpressure and mid-operation reset sequences.
module tb_addsub_sequencer;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_sequencer_if #(.WIDTH(W)) bus ();

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_q;
  logic         add_cout;

  // Behavioural stand-in for the RCA_4 adder (no carry-in)
  assign {add_cout, add_q} = {1'b0, add_a} + {1'b0, add_b};

  addsub_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_q    (add_q),
    .add_cout (add_cout)
  );

  typedef struct {
    int a;
    int b;
    int op;
    int q;
    int c;
    int z;
    int n;
    int v;
    int lat;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Plain two's-complement arithmetic reference
  function automatic void ref_model(input int a, input int b, input int op,
                                    output int q, output int c, output int z,
                                    output int n, output int v);
    int sa, sb, r, sr;
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    if (op == 0) begin
      r  = a + b;
      c  = (r >= M) ? 1 : 0;
      sr = sa + sb;
    end else begin
      r  = a - b;
      c  = (a >= b) ? 1 : 0;
      sr = sa - sb;
    end
    q = ((r % M) + M) % M;
    z = (q == 0) ? 1 : 0;
    n = (q >= M/2) ? 1 : 0;
    v = (sr > M/2 - 1 || sr < -(M/2)) ? 1 : 0;
  endfunction

  // Issue one operation and wait (bounded) for out_valid; lat counts edges after the accept edge
  task automatic applyStimulus(input int a, input int b, input int op, output int lat);
    @(negedge clk);
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = W'(a);
    bus.in_b     = W'(b);
    bus.in_op    = op[0];
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_op    = 1'($urandom);
    check("in_ready_busy", int'(bus.in_ready), 0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic checkOutput(input string tag, input int q, input int c, input int z,
                             input int n, input int v, input int exp_lat, input int lat);
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_q"}, int'(bus.out_q), q);
    check({tag, "_c"}, int'(bus.out_c), c);
    check({tag, "_z"}, int'(bus.out_z), z);
    check({tag, "_n"}, int'(bus.out_n), n);
    check({tag, "_v"}, int'(bus.out_v), v);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic releaseOutput();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("valid_drop", int'(bus.out_valid), 0);
    check("ready_return", int'(bus.in_ready), 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, q, c, z, n, v, rose, stable;
    int ea, eb, eop;

    vecs[0] = '{a:3, b:4, op:0, q:7,  c:0, z:0, n:0, v:0, lat:2};
    vecs[1] = '{a:9, b:8, op:0, q:1,  c:1, z:0, n:0, v:1, lat:2};
    vecs[2] = '{a:4, b:4, op:0, q:8,  c:0, z:0, n:1, v:1, lat:2};
    vecs[3] = '{a:5, b:3, op:1, q:2,  c:1, z:0, n:0, v:0, lat:3};
    vecs[4] = '{a:3, b:5, op:1, q:14, c:0, z:0, n:1, v:0, lat:3};
    vecs[5] = '{a:0, b:0, op:1, q:0,  c:1, z:1, n:0, v:0, lat:3};
    vecs[6] = '{a:7, b:8, op:1, q:15, c:0, z:0, n:1, v:1, lat:3};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_q", int'(bus.out_q), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].c, vecs[i].z,
                  vecs[i].n, vecs[i].v, vecs[i].lat, lat);
      releaseOutput();
    end

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      ea  = int'($urandom_range(0, M - 1));
      eb  = int'($urandom_range(0, M - 1));
      eop = int'($urandom_range(0, 1));
      ref_model(ea, eb, eop, q, c, z, n, v);
      applyStimulus(ea, eb, eop, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d", i), q, c, z, n, v, (eop != 0) ? 3 : 2, lat);
      releaseOutput();
    end

    $display("[TB] backpressure");
    ref_model(6, 5, 0, q, c, z, n, v);
    applyStimulus(6, 5, 0, lat);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd1;
      bus.in_b     = 4'd1;
      bus.in_op    = 1'b1;
      if (!bus.out_valid || bus.in_ready || int'(bus.out_q) != q || int'(bus.out_v) != v)
        stable = 0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_stable", stable, 1);
    checkOutput("bp", q, c, z, n, v, 2, lat);
    releaseOutput();
    ref_model(2, 3, 0, q, c, z, n, v);
    applyStimulus(2, 3, 0, lat);
    checkOutput("bp_next", q, c, z, n, v, 2, lat);
    releaseOutput();

    $display("[TB] reset during PASS2");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd9;
    bus.in_b     = 4'd2;
    bus.in_op    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", int'(bus.in_ready), 1);
    check("midrst_q_zero", int'(bus.out_q), 0);
    check("midrst_flags_zero",
          int'({bus.out_c, bus.out_z, bus.out_n, bus.out_v}), 0);
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) rose = 1;
    end
    check("midrst_no_valid", rose, 0);
    applyStimulus(1, 1, 0, lat);
    checkOutput("midrst_add", 2, 0, 0, 0, 0, 2, lat);
    releaseOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
